// File: rtl/frame_fetch_arbiter_if.sv
// Bus bundle for frame_fetch_arbiter: pixel-writer request, SRAM port and line-buffer write port.
// slave = arbiter side, master = requester/SRAM/line-buffer side.
interface frame_fetch_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    // Writer handshake: i_wr_req is the valid; i_wr_addr/i_wr_data stay stable while it is
    // high. o_wr_ack is the ready and is combinational: a cycle with both high commits one
    // word to SRAM in that same cycle, and the requester may present the next word after it.
    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ack;

    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_lb_we;
    logic              o_lb_bank;
    logic [15:0]       o_lb_addr;
    logic [DATA_W-1:0] o_lb_data;

    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_mem_rdata,
        output o_wr_ack, o_mem_addr, o_mem_we, o_mem_wdata,
               o_lb_we, o_lb_bank, o_lb_addr, o_lb_data
    );

    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_mem_rdata,
        input  o_wr_ack, o_mem_addr, o_mem_we, o_mem_wdata,
               o_lb_we, o_lb_bank, o_lb_addr, o_lb_data
    );
endinterface

// File: rtl/frame_fetch_arbiter.sv
// Shares one single-port pixel SRAM between the display line prefetch and a pixel writer.
// Optional statistics counters are enabled with `define FRAME_FETCH_ARBITER_STATS_EN.
module frame_fetch_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 640,
    parameter int V_ACT      = 480,
    parameter int BASE_ADDR  = 0
) (
    input  logic        clk_25M,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_line,
    output logic        o_start_display,
    output logic        o_disp_bank,
    output logic        o_underrun,
    output logic [1:0]  o_dbg_state,
`ifdef FRAME_FETCH_ARBITER_STATS_EN
    output logic [15:0] o_wr_stall_cnt,
    output logic [15:0] o_fetch_cnt,
`endif
    frame_fetch_arbiter_if.slave io_bus
);
    localparam int CNT_W = $clog2(LINE_WORDS + 1);
    localparam int ROW_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam logic [CNT_W-1:0]  LAST_K     = CNT_W'(LINE_WORDS);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(V_ACT - 1);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(LINE_WORDS);

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_PRELOAD = 2'd1,
        S_IDLE    = 2'd2,
        S_FETCH   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_en_q;
    logic [CNT_W-1:0]  r_k;
    logic [ROW_W-1:0]  r_fetch_row;
    logic [ADDR_W-1:0] r_burst_base;
    logic [ADDR_W-1:0] r_next_base;
    logic              r_rd_vld;
    logic [15:0]       r_lb_addr;
    logic              r_lb_bank;
    logic              r_disp_bank;
    logic              r_underrun;
    logic              r_start;

    logic              w_tail;
    logic              w_en_rise;
    logic              w_issue;
    logic              w_line_fetch;
    logic              w_underrun_evt;
    logic              w_wr_go;
    logic [ADDR_W-1:0] w_mem_addr;

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) r_state <= S_OFF;
        else     r_state <= w_next;
    end

    // r_k == LINE_WORDS is the trailing cycle: no address, last word lands in the line buffer.
    always_comb begin
        w_next         = r_state;
        w_tail         = (r_k == LAST_K);
        w_en_rise      = 1'b0;
        w_issue        = 1'b0;
        w_line_fetch   = 1'b0;
        w_underrun_evt = 1'b0;
        w_wr_go        = 1'b0;
        case (r_state)
            S_OFF: begin
                w_en_rise = i_enable && !r_en_q;
                if (w_en_rise) w_next = S_PRELOAD;
            end
            S_PRELOAD: begin
                w_issue = !w_tail;
                if (w_tail) w_next = S_IDLE;
            end
            S_IDLE: begin
                w_wr_go = io_bus.i_wr_req;
                if (i_line) begin
                    w_line_fetch = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_FETCH: begin
                w_line_fetch   = i_line;
                w_underrun_evt = i_line && !w_tail;
                w_issue        = !w_tail && !i_line;
                if (i_line)      w_next = S_FETCH;
                else if (w_tail) w_next = S_IDLE;
            end
            default: w_next = S_OFF;
        endcase

        w_mem_addr = '0;
        if (w_issue)      w_mem_addr = r_burst_base + ADDR_W'(r_k);
        else if (w_wr_go) w_mem_addr = io_bus.i_wr_addr;
    end

    // The row counter advances when a burst starts, so an aborted row is skipped, not retried.
    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            r_en_q       <= 1'b0;
            r_k          <= '0;
            r_fetch_row  <= '0;
            r_burst_base <= '0;
            r_next_base  <= '0;
            r_rd_vld     <= 1'b0;
            r_lb_addr    <= '0;
            r_lb_bank    <= 1'b0;
            r_disp_bank  <= 1'b0;
            r_underrun   <= 1'b0;
            r_start      <= 1'b0;
        end else begin
            r_en_q   <= i_enable;
            r_rd_vld <= w_issue;
            r_start  <= (r_state == S_PRELOAD) && w_tail;
            if (w_issue) begin
                r_k       <= r_k + CNT_W'(1);
                r_lb_addr <= 16'(r_k);
            end
            if (w_en_rise) begin
                r_k          <= '0;
                r_lb_bank    <= 1'b0;
                r_burst_base <= BASE;
                if (V_ACT > 1) begin
                    r_fetch_row <= ROW_W'(1);
                    r_next_base <= BASE + ROW_STRIDE;
                end else begin
                    r_fetch_row <= '0;
                    r_next_base <= BASE;
                end
            end
            if (w_line_fetch) begin
                r_k          <= '0;
                r_disp_bank  <= ~r_disp_bank;
                r_lb_bank    <= r_disp_bank;
                r_burst_base <= r_next_base;
                if (r_fetch_row == LAST_ROW) begin
                    r_fetch_row <= '0;
                    r_next_base <= BASE;
                end else begin
                    r_fetch_row <= r_fetch_row + ROW_W'(1);
                    r_next_base <= r_next_base + ROW_STRIDE;
                end
            end
            if (w_underrun_evt) r_underrun <= 1'b1;
        end
    end

    assign io_bus.o_mem_addr  = w_mem_addr;
    assign io_bus.o_mem_we    = w_wr_go;
    assign io_bus.o_mem_wdata = w_wr_go ? io_bus.i_wr_data : '0;
    assign io_bus.o_wr_ack    = w_wr_go;
    assign io_bus.o_lb_we     = r_rd_vld;
    assign io_bus.o_lb_bank   = r_lb_bank;
    assign io_bus.o_lb_addr   = r_lb_addr;
    assign io_bus.o_lb_data   = r_rd_vld ? io_bus.i_mem_rdata : '0;
    assign o_start_display    = r_start;
    assign o_disp_bank        = r_disp_bank;
    assign o_underrun         = r_underrun;
    assign o_dbg_state        = r_state;

`ifdef FRAME_FETCH_ARBITER_STATS_EN
    logic [15:0] r_wr_stall_cnt;
    logic [15:0] r_fetch_cnt;
    logic        w_complete;

    assign w_complete = w_tail && ((r_state == S_PRELOAD) || (r_state == S_FETCH));

    always_ff @(posedge clk_25M or posedge rst) begin
        if (rst) begin
            r_wr_stall_cnt <= '0;
            r_fetch_cnt    <= '0;
        end else begin
            if ((r_state != S_OFF) && io_bus.i_wr_req && !w_wr_go && (r_wr_stall_cnt != 16'hFFFF))
                r_wr_stall_cnt <= r_wr_stall_cnt + 16'd1;
            if (w_complete) r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end

    assign o_wr_stall_cnt = r_wr_stall_cnt;
    assign o_fetch_cnt    = r_fetch_cnt;
`endif
endmodule

// File: doc/frame_fetch_arbiter.md
Name: frame_fetch_arbiter

Overview:
- Shares one single-port pixel SRAM between two requesters:
  - the display line prefetch, which feeds a double-banked line buffer ahead of the VGA timing generator;
  - the image-processing pixel writer.
- Sequences display start-up: preloads row 0, then issues a one-cycle start pulse to the timing generator.
- Re-fetches the next row on every active-line pulse.
- Display fetch always has priority; writes use idle memory cycles.

Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM/pixel word width
- LINE_WORDS, 640, words fetched per row
- V_ACT, 480, active rows per frame
- BASE_ADDR, 0, SRAM address of row 0 word 0

Ports:
- clk_25M  input  1  pixel clock; only clock
- rst  input  1  asynchronous, active-high reset
- i_enable  input  1  level; rising edge (sampled) starts preload sequence
- i_line  input  1  one-cycle pulse at start of each active display line
- o_start_display  output  1  one-cycle pulse to timing generator after preload completes
- i_wr_req  input  1  writer request; held with addr/data until acked
- i_wr_addr  input  ADDR_W  writer word address
- i_wr_data  input  DATA_W  writer data
- o_wr_ack  output  1  one-cycle pulse; write committed this cycle
- o_mem_addr  output  ADDR_W  SRAM address
- o_mem_we  output  1  SRAM write enable (active-high)
- o_mem_wdata  output  DATA_W  SRAM write data
- i_mem_rdata  input  DATA_W  SRAM read data, valid 1 cycle after address
- o_lb_we  output  1  line-buffer write strobe
- o_lb_bank  output  1  line-buffer bank being filled
- o_lb_addr  output  16  word index within row
- o_lb_data  output  DATA_W  line-buffer write data
- o_disp_bank  output  1  bank the display reads
- o_underrun  output  1  sticky: fetch still active when i_line arrived

Behaviour:
- Reset:
  - all outputs 0;
  - state OFF;
  - fetch_row = 0, word counter = 0;
  - o_disp_bank = 0; o_lb_bank = 0.
- States:
  - OFF: ignores i_line and i_wr_req. On i_enable rising edge (0 in previous cycle, 1 now) -> PRELOAD with target row 0, bank 0.
  - PRELOAD: issues LINE_WORDS reads, one per cycle.
    - Address = BASE_ADDR + row*LINE_WORDS + k, k = 0..LINE_WORDS-1; o_mem_we = 0.
    - After the last address, waits 1 cycle for the final read data.
    - Then pulses o_start_display for 1 cycle and moves to IDLE with fetch_row = 1.
  - IDLE:
    - If a fetch is pending -> FETCH next cycle.
    - Otherwise, if i_wr_req: drive o_mem_addr = i_wr_addr, o_mem_wdata = i_wr_data, o_mem_we = 1, o_wr_ack = 1 in the same cycle (combinational ack, registered memory controls not allowed to add latency). One write per cycle while the request is held.
  - FETCH:
    - Same read burst as PRELOAD into bank ~o_disp_bank; writes stalled (o_wr_ack = 0).
    - Fetch completes 1 cycle after the last read address, then -> IDLE.
    - fetch_row increments; after V_ACT-1 it wraps to 0.
- i_line in IDLE, FETCH or the cycle a fetch completes:
  - toggles o_disp_bank;
  - sets fetch pending, targeting the bank just released by the display.
- i_line during an active FETCH (counter not at end):
  - sets o_underrun (sticky until rst);
  - aborts the current burst and restarts from word 0 for the next row, so row order is kept.
- Line-buffer writes:
  - o_lb_we, o_lb_addr = k, o_lb_data = i_mem_rdata asserted exactly 1 cycle after each read address;
  - o_lb_bank is held over the whole burst including the trailing cycle.
- i_line coincident with i_wr_req in IDLE: the write completes that cycle; the fetch starts next cycle.
- Address arithmetic is unsigned, ADDR_W bits, wrap-around permitted.
- Assertion of rst mid-burst returns to OFF immediately. No o_start_display pulse until the next i_enable rising edge.
- Deasserting i_enable has no effect once started; only rst stops the block.

Optional Feature:
- Macro FRAME_FETCH_ARBITER_STATS_EN.
- When defined, adds outputs:
  - o_wr_stall_cnt [15:0]: counts cycles with i_wr_req=1 and o_wr_ack=0 in non-OFF states; saturates at 16'hFFFF.
  - o_fetch_cnt [15:0]: counts completed fetches including preload; wraps.
  - Both clear on rst.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Preload sequence:
  - Setup: LINE_WORDS=8, V_ACT=4, BASE_ADDR=0x100; raise i_enable.
  - Reads at addresses 0x100..0x107 on 8 consecutive cycles.
  - o_lb_we on bank 0 indices 0..7, each 1 cycle later.
  - o_start_display pulses exactly 1 cycle after the final o_lb_we.
- Next-row fetch:
  - Stimulus: i_line pulse after preload.
  - o_disp_bank -> 1; fetch of 0x108..0x10F into bank 0.
  - Successive i_line pulses fetch rows 2, 3, then row 0 (0x100) again (wrap).
- Write arbitration:
  - Stimulus: i_wr_req held with addr 0x00050, data 0xBEEF while IDLE.
  - o_mem_we=1, o_wr_ack=1 the same cycle.
  - If i_wr_req is held across a FETCH, no ack occurs for 9 cycles; the ack resumes in the first IDLE cycle.
- Simultaneous i_line and i_wr_req in IDLE: write acked that cycle; first fetch read address issued the next cycle.
- Underrun:
  - Stimulus: second i_line 3 cycles into a fetch.
  - o_underrun=1 and stays 1.
  - Burst restarts at word 0 of the following row.
  - rst clears o_underrun.
- Reset mid-preload: rst at word 4 -> all outputs 0, no o_start_display. A new i_enable edge redoes the preload from 0x100.
